axis_frame_tx: RTL and testbench
================================

# axis_frame_tx

Frame-buffered AXI4-Stream transmitter for the 2017E spectrum chain: the source end of the complex-sample stream that the CORDIC magnitude stage and the `find_max_b` peak finder consume. Complex samples (re/im) are loaded by address into an internal buffer. On `start`, one frame of `FRAME_LEN` beats is replayed with full `tvalid`/`tready` backpressure and `tlast` on the final beat. It replaces ad-hoc counter-driven stream feeders and serves as a loopback source for hardware bring-up.

## Interface
- `DATA_WIDTH`, 24, width of each of re/im (signed two's complement)
- `ADDR_WIDTH`, 8, buffer address width
- `FRAME_LEN`, 128, beats per frame; legal range 2..2^ADDR_WIDTH
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  ADDR_WIDTH  write address
- `wr_data_re`  in  DATA_WIDTH  real sample
- `wr_data_im`  in  DATA_WIDTH  imaginary sample
- `start`  in  1  single-cycle request to transmit one frame
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the final handshake
- `m_axis_tvalid`  out  1  beat valid
- `m_axis_tready`  in  1  downstream ready
- `m_axis_tdata`  out  2*DATA_WIDTH  {im, re}; re in the LSBs
- `m_axis_tlast`  out  1  high on beat FRAME_LEN-1
- `m_axis_taddr`  out  ADDR_WIDTH  index of the current beat, 0..FRAME_LEN-1

## Operation
- Buffer: 2^ADDR_WIDTH × 2*DATA_WIDTH. Single write port, single synchronous read port with 1-cycle latency. Infers block RAM. Contents are not cleared by `rst`.
- FSM states:
  - IDLE: accepts `start`, then goes to PRIME.
  - PRIME: issues read of address 0, then goes to STREAM.
  - STREAM: advances on each handshake. After the handshake on beat FRAME_LEN-1, goes to DONE.
  - DONE: pulses `done`, then returns to IDLE.
- Output register holds {tdata, tlast, taddr}. It reloads from the RAM output only when `!tvalid` or `tvalid & tready`. The read of the next address is issued in the same cycle.
- Backpressure: while `tvalid & !tready`, `tdata`, `tlast` and `taddr` hold exactly. Once asserted, `tvalid` does not drop before the handshake.
- Writes while `busy` are dropped, so frame contents are frozen for the duration of the frame. Writes in IDLE or DONE take effect the next cycle.
- `start` while `busy` is ignored (no queuing).
- `start` in the same cycle as a write in IDLE: the write is committed first, and the frame sees the new data.
- Read address counter stops at FRAME_LEN-1 and does not wrap. Beat index equals buffer address.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_taddr`=0, `busy`=0, `done`=0. FSM goes to IDLE.
- `start` sampled high in cycle 0:
  - `busy` rises in cycle 1.
  - First `tvalid` in cycle 2, carrying addr 0.
- With `tready` tied high:
  - One beat per cycle on cycles 2..FRAME_LEN+1.
  - `tlast` in cycle FRAME_LEN+1.
  - `done` in cycle FRAME_LEN+2, with `busy` falling in the same cycle.
- Minimum start-to-start interval: FRAME_LEN+3 cycles.
- `rst` mid-frame: outputs return to reset values on the next edge. No `done` is generated. A following `start` replays from addr 0.

## Structure
- Shared package `nuedc_axis_pkg`:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - Complex-sample packing constant (re LSB).
  - FSM state encoding (IDLE, PRIME, STREAM, DONE).
- One sub-module: `sdp_ram`, a simple dual-port RAM with 1-cycle registered read and parameterised width/depth. It is reusable by other capture buffers.

## Test plan
- Load addr k with re=k, im=-k (k=0..127), `start`, `tready`=1 → 128 beats:
  - `tdata[23:0]`=k, `tdata[47:24]`=-k.
  - `tlast` only at k=127.
  - `done` exactly 1 cycle after that beat.
  - Total latency start→done = 130 cycles.
- Same frame with `tready` random at 50% → identical beat sequence. `tdata`/`tlast`/`taddr` stable during every stalled cycle. `tvalid` never drops before its handshake.
- `start` pulsed at beat 40, and writes of 0xFFFFFF to addr 100 mid-frame → second start ignored. Beat 100 still carries the original value. A later frame sees 0xFFFFFF.
- `rst` asserted at beat 60 for 1 cycle → `tvalid`=0 and `busy`=0 next cycle, no `done`. A new `start` replays from addr 0 with the buffer contents intact.
- `tready`=0 held for 20 cycles at the `tlast` beat → `tlast` beat held. `done` fires 1 cycle after `tready` finally rises.
- `start` and `wr_en` (addr 0, re=0x123456) in the same IDLE cycle → beat 0 carries re=0x123456.

Source files
------------

// File: rtl/nuedc_axis_pkg.sv
// Shared definitions for the spectrum-chain stream blocks.
// Holds default bus widths, the complex-sample packing order and the
// frame transmitter FSM encoding. No ports.
package nuedc_axis_pkg;

  // Default widths: 24-bit re/im samples, 256-entry frame buffer.
  localparam int DATA_WIDTH_DEF = 24;
  localparam int ADDR_WIDTH_DEF = 8;

  // Complex words are packed {im, re}, re occupying the low half.
  localparam int CPLX_RE_SLOT = 0;

  // Frame transmitter FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/axis_frame_tx_if.sv
// AXI4-Stream beat bus carrying complex samples plus a beat index.
// Ports: tvalid/tready handshake, tdata {im, re}, tlast, taddr.
// Backpressure: master holds tdata/tlast/taddr while tvalid & !tready.
interface axis_frame_tx_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 8
) ();
  logic                    tvalid;
  logic                    tready;
  logic [2*DATA_WIDTH-1:0] tdata;
  logic                    tlast;
  logic [ADDR_WIDTH-1:0]   taddr;

  modport master (output tvalid, output tdata, output tlast, output taddr, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input taddr, output tready);
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid the cycle after rd_en_i; holds while rd_en_i is low.
// Ports: clk, rst (clears only the read register), wr_*_i, rd_en_i, rd_addr_i, rd_data_o.
module sdp_ram #(
  parameter int WIDTH      = 48,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rd_data_q;

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register with synchronous reset, matching the RAM output latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_frame_tx.sv
// Frame-buffered AXI4-Stream transmitter: replays FRAME_LEN buffered complex beats per start.
// Latency: start in cycle 0 -> busy cycle 1 -> first beat cycle 2; done 1 cycle after last handshake.
// Backpressure: full tvalid/tready; beat held exactly while stalled. Ports: clk, rst, wr_*, start, busy, done, m_axis.
module axis_frame_tx
  import nuedc_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FRAME_LEN  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data_re,
  input  logic [DATA_WIDTH-1:0] wr_data_im,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  axis_frame_tx_if.master       m_axis
);

  localparam int RE_LSB = CPLX_RE_SLOT * DATA_WIDTH;
  localparam int IM_LSB = (1 - CPLX_RE_SLOT) * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  logic [1:0]              state_q, state_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [ADDR_WIDTH-1:0]   taddr_q, taddr_d;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    wr_accept;
  logic [2*DATA_WIDTH-1:0] wr_word;
  logic [2*DATA_WIDTH-1:0] rd_word;
  logic                    handshake;

  // busy and done decode straight from the state register so both are glitch-free.
  assign busy = (state_q == ST_PRIME) || (state_q == ST_STREAM);
  assign done = (state_q == ST_DONE);

  // Frame contents are frozen while a frame is in flight.
  assign wr_accept = wr_en && !busy;

  always_comb begin
    wr_word = '0;
    wr_word[RE_LSB +: DATA_WIDTH] = wr_data_re;
    wr_word[IM_LSB +: DATA_WIDTH] = wr_data_im;
  end

  assign handshake = tvalid_q && m_axis.tready;
  assign addr_nxt  = taddr_q + ADDR_WIDTH'(1);

  // The RAM read register doubles as the tdata stage: it is only read when the
  // beat register reloads, so tdata holds together with tlast/taddr under stall.
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    taddr_d  = taddr_q;
    rd_en    = 1'b0;
    rd_addr  = addr_nxt;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        rd_en    = 1'b1;
        rd_addr  = '0;
        tvalid_d = 1'b1;
        taddr_d  = '0;
        tlast_d  = (LAST_ADDR == '0);
        state_d  = ST_STREAM;
      end
      ST_STREAM: begin
        if (handshake) begin
          if (tlast_q) begin
            // Address counter stays at the last beat; no wrap.
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = ST_DONE;
          end else begin
            rd_en   = 1'b1;
            taddr_d = addr_nxt;
            tlast_d = (addr_nxt == LAST_ADDR);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      taddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      taddr_q  <= taddr_d;
    end
  end

  sdp_ram #(
    .WIDTH      (2 * DATA_WIDTH),
    .DEPTH_LOG2 (ADDR_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_word),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_word)
  );

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = rd_word;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.taddr  = taddr_q;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Self-checking bench for axis_frame_tx: scoreboard of expected beats per frame.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Covers reset, full-rate and random-stall frames, frozen buffer, mid-frame reset, tlast stall.
module tb_axis_frame_tx;
  localparam int DW = 24;
  localparam int AW = 8;
  localparam int FL = 128;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] data;
    logic            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data_re = '0;
  logic [DW-1:0] wr_data_im = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          tready = 1'b0;

  axis_frame_tx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_axis_if ();
  assign m_axis_if.tready = tready;

  axis_frame_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data_re (wr_data_re),
    .wr_data_im (wr_data_im),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .m_axis     (m_axis_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  logic [2*DW-1:0] mem [FL];
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    beat_t b;
    for (int i = 0; i < FL; i++) begin
      b.addr = AW'(i);
      b.data = mem[i];
      b.last = (i == FL - 1);
      exp_q.push_back(b);
    end
  endtask

  // Raise start for one cycle; on return the bench is in cycle 1 of the frame.
  task automatic start_frame();
    start = 1'b1;
    t0 = cyc;
    push_frame();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_rdy);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
      @(posedge clk);
      #1;
      if (rnd_rdy) tready = ($urandom_range(0, 1) == 1);
    end
    if (n >= budget) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Output monitor: scoreboard pops, stall stability, done placement.
  bit                     stall_prev = 1'b0;
  bit                     last_hs_prev = 1'b0;
  logic [2*DW+AW:0]       held;
  beat_t                  eb;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev   = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_vld", 64'(m_axis_if.tvalid), 64'd1);
        chk("stall_hold", 64'({m_axis_if.tdata, m_axis_if.tlast, m_axis_if.taddr}), 64'(held));
      end
      if (m_axis_if.tvalid && tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          eb = exp_q.pop_front();
          chk("beat_addr", 64'(m_axis_if.taddr), 64'(eb.addr));
          chk("beat_data", 64'(m_axis_if.tdata), 64'(eb.data));
          chk("beat_last", 64'(m_axis_if.tlast), 64'(eb.last));
        end
      end
      if (last_hs_prev || done) chk("done_timing", 64'(done), 64'(last_hs_prev));
      if (done) chk("busy_fall", 64'(busy), 64'd0);
      last_hs_prev = m_axis_if.tvalid && tready && m_axis_if.tlast;
      stall_prev   = m_axis_if.tvalid && !tready;
      held         = {m_axis_if.tdata, m_axis_if.tlast, m_axis_if.taddr};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tvalid", 64'(m_axis_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_if.tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_if.tdata), 64'd0);
    chk("rst_taddr", 64'(m_axis_if.taddr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;

    // Load re=k, im=-k.
    for (int k = 0; k < FL; k++) begin
      wr_en      = 1'b1;
      wr_addr    = AW'(k);
      wr_data_re = DW'(k);
      wr_data_im = DW'(-k);
      mem[k]     = {DW'(-k), DW'(k)};
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Frame at full rate.
    tready = 1'b1;
    start_frame();
    @(negedge clk);
    chk("busy_c1", 64'(busy), 64'd1);
    chk("vld_c1", 64'(m_axis_if.tvalid), 64'd0);
    tick();
    @(negedge clk);
    chk("vld_c2", 64'(m_axis_if.tvalid), 64'd1);
    wait_done(400, 1'b0);
    chk("lat_full", 64'(cyc - t0), 64'd130);
    chk("sb_empty1", 64'(exp_q.size()), 64'd0);
    tick();

    // Same frame with random backpressure.
    start_frame();
    wait_done(3000, 1'b1);
    tready = 1'b1;
    chk("sb_empty2", 64'(exp_q.size()), 64'd0);
    tick();

    // Start and write to addr 100 at beat 40: both ignored.
    start_frame();
    repeat (41) tick();
    start      = 1'b1;
    wr_en      = 1'b1;
    wr_addr    = 8'd100;
    wr_data_re = 24'hFFFFFF;
    wr_data_im = 24'hFFFFFF;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    wait_done(400, 1'b0);
    chk("lat_ign", 64'(cyc - t0), 64'd130);
    repeat (3) tick();
    @(negedge clk);
    chk("start_ignored", 64'(busy), 64'd0);
    chk("idle_vld", 64'(m_axis_if.tvalid), 64'd0);
    chk("sb_empty3", 64'(exp_q.size()), 64'd0);

    // Rewrite addr 100 in IDLE; the next frame sees it.
    tick();
    wr_en      = 1'b1;
    wr_addr    = 8'd100;
    wr_data_re = 24'hFFFFFF;
    wr_data_im = 24'hFFFFFF;
    mem[100]   = {24'hFFFFFF, 24'hFFFFFF};
    tick();
    wr_en = 1'b0;
    start_frame();
    wait_done(400, 1'b0);
    chk("sb_empty4", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset at beat 60.
    start_frame();
    repeat (61) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_tvalid", 64'(m_axis_if.tvalid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_taddr", 64'(m_axis_if.taddr), 64'd0);
    repeat (4) tick();
    start_frame();
    wait_done(400, 1'b0);
    chk("sb_empty5", 64'(exp_q.size()), 64'd0);
    tick();

    // Hold tready low for 20 cycles on the tlast beat.
    start_frame();
    repeat (128) tick();
    tready = 1'b0;
    @(negedge clk);
    chk("tlast_beat", 64'(m_axis_if.tlast), 64'd1);
    repeat (20) tick();
    @(negedge clk);
    chk("tlast_held", 64'(m_axis_if.tlast), 64'd1);
    tready = 1'b1;
    wait_done(400, 1'b0);
    chk("lat_stall", 64'(cyc - t0), 64'd150);
    tick();

    // Write and start in the same IDLE cycle.
    wr_en      = 1'b1;
    wr_addr    = 8'd0;
    wr_data_re = 24'h123456;
    wr_data_im = 24'h000000;
    mem[0]     = {24'h000000, 24'h123456};
    start_frame();
    wr_en = 1'b0;
    wait_done(400, 1'b0);
    chk("sb_empty6", 64'(exp_q.size()), 64'd0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
